interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 25 ++
 rtl/interrupt_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// CPU-side bus of the interrupt controller: mask programming, request
// presentation and the acknowledge / end-of-interrupt handshake.
// The controller connects through the slave modport, the CPU or bench through master.
interface interrupt_controller_if;
  logic        i_mask_we;
  logic [1:0]  i_mask;
  logic        i_ack;
  logic        i_eoi;
  logic        o_int_req;
  logic [15:0] o_int_vector;
  logic        o_int_id;
  logic [1:0]  o_pending;
  logic [1:0]  o_mask;
  logic        o_busy;

  modport master (
    output i_mask_we, i_mask, i_ack, i_eoi,
    input  o_int_req, o_int_vector, o_int_id, o_pending, o_mask, o_busy
  );

  modport slave (
    input  i_mask_we, i_mask, i_ack, i_eoi,
    output o_int_req, o_int_vector, o_int_id, o_pending, o_mask, o_busy
  );
endinterface

// File: rtl/interrupt_controller.sv
// Two-source interrupt controller.
// Each asynchronous request passes through a 2-flop synchronizer and a
// registered rising-edge detector; detected edges latch into pending bits
// independently of the mask. An IDLE -> REQ -> SERVICE state machine presents
// the highest-priority unmasked source (A over B) to the CPU and tracks its
// service until end-of-interrupt.
// Optional feature macro: INTC_NESTING_EN adds one level of nesting, letting A
// preempt an in-service B (state SERVICE_NESTED, one-entry id/vector stack).
module interrupt_controller #(
  parameter logic [15:0] VEC_A = 16'hFF00,
  parameter logic [15:0] VEC_B = 16'hFF04
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inta,
  input  logic                  i_intb,
  interrupt_controller_if.slave bus
);

`ifdef INTC_NESTING_EN
  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    REQ            = 2'd1,
    SERVICE        = 2'd2,
    SERVICE_NESTED = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;
`endif

  // Synchronizer / edge detector state, bit0 = A, bit1 = B.
  logic [1:0]  sync1_r;
  logic [1:0]  sync2_r;
  logic [1:0]  prev_r;
  // Counts the edges since reset so the detector only compares real samples.
  logic [2:0]  vld_r;
  logic [1:0]  edge_s;

  logic [1:0]  pending_r;
  logic [1:0]  clr_s;
  logic [1:0]  mask_r;
  logic [1:0]  unmasked_s;

  state_t      state_r;
  logic        req_r;
  logic [15:0] vector_r;
  logic        id_r;
  logic        busy_r;

`ifdef INTC_NESTING_EN
  logic        stack_id_r;
  logic [15:0] stack_vec_r;
`endif

  // Synchronize both request lines and keep the previous synchronized value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      prev_r  <= 2'b00;
      vld_r   <= 3'b000;
    end else begin
      sync1_r <= {i_intb, i_inta};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      vld_r   <= {vld_r[1:0], 1'b1};
    end
  end

  // Rising edge only once both compared samples were taken after reset, so a
  // line held high through reset is not mistaken for a new edge.
  always_comb begin
    edge_s = 2'b00;
    if (vld_r[2]) begin
      edge_s = sync2_r & ~prev_r;
    end else begin
      edge_s = 2'b00;
    end
  end

  // Pending bit to clear on acknowledge of the presented source.
  always_comb begin
    clr_s = 2'b00;
    case (state_r)
      REQ: begin
        if (bus.i_ack) begin
          clr_s = id_r ? 2'b10 : 2'b01;
        end else begin
          clr_s = 2'b00;
        end
      end
`ifdef INTC_NESTING_EN
      SERVICE: begin
        // A nested request is always source A.
        if (req_r && bus.i_ack) begin
          clr_s = 2'b01;
        end else begin
          clr_s = 2'b00;
        end
      end
`endif
      default: begin
        clr_s = 2'b00;
      end
    endcase
  end

  // Pending latch: a new edge wins over a same-cycle clear; repeat edges are absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 2'b00;
    end else begin
      pending_r <= (pending_r & ~clr_s) | edge_s;
    end
  end

  // Mask register, all sources masked out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= 2'b11;
    end else if (bus.i_mask_we) begin
      mask_r <= bus.i_mask;
    end else begin
      mask_r <= mask_r;
    end
  end

  assign unmasked_s = pending_r & ~mask_r;

  // Request / service state machine with registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_r       <= 1'b0;
      vector_r    <= 16'h0000;
      id_r        <= 1'b0;
      busy_r      <= 1'b0;
`ifdef INTC_NESTING_EN
      stack_id_r  <= 1'b0;
      stack_vec_r <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (unmasked_s != 2'b00) begin
            state_r <= REQ;
            req_r   <= 1'b1;
            if (unmasked_s[0]) begin
              id_r     <= 1'b0;
              vector_r <= VEC_A;
            end else begin
              id_r     <= 1'b1;
              vector_r <= VEC_B;
            end
          end
        end
        REQ: begin
          // The presented source is held until acknowledged, whatever the mask does.
          if (bus.i_ack) begin
            state_r <= SERVICE;
            req_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        SERVICE: begin
`ifdef INTC_NESTING_EN
          if (req_r) begin
            // Nested A is being presented over the in-service B.
            if (bus.i_ack) begin
              state_r <= SERVICE_NESTED;
              req_r   <= 1'b0;
            end else if (bus.i_eoi) begin
              // B finished first; A stays pending and is re-arbitrated from IDLE.
              state_r <= IDLE;
              req_r   <= 1'b0;
              busy_r  <= 1'b0;
            end
          end else if (bus.i_eoi) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (id_r && unmasked_s[0]) begin
            // The outputs are about to show A, so B's context is stacked now;
            // it is only used once the nested acknowledge has happened.
            req_r       <= 1'b1;
            stack_id_r  <= id_r;
            stack_vec_r <= vector_r;
            id_r        <= 1'b0;
            vector_r    <= VEC_A;
          end
`else
          if (bus.i_eoi) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
`endif
        end
`ifdef INTC_NESTING_EN
        SERVICE_NESTED: begin
          // Return to the preempted source with busy still asserted.
          if (bus.i_eoi) begin
            state_r  <= SERVICE;
            id_r     <= stack_id_r;
            vector_r <= stack_vec_r;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_int_req    = req_r;
  assign bus.o_int_vector = vector_r;
  assign bus.o_int_id     = id_r;
  assign bus.o_pending    = pending_r;
  assign bus.o_mask       = mask_r;
  assign bus.o_busy       = busy_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_interrupt_controller;
  logic clk;
  logic rst;
  logic i_inta;
  logic i_intb;
  int   pass_cnt;
  int   tot_cnt;

  interrupt_controller_if bus();

  interrupt_controller #(
    .VEC_A(16'hFF00),
    .VEC_B(16'hFF04)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_inta(i_inta),
    .i_intb(i_intb),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL rst_req act=%b exp=0", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'h0000) $display("FAIL rst_vec act=%h exp=0000", bus.o_int_vector); else pass_cnt++;
    tot_cnt++; if (bus.o_int_id !== 1'b0) $display("FAIL rst_id act=%b exp=0", bus.o_int_id); else pass_cnt++;
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL rst_pend act=%b exp=00", bus.o_pending); else pass_cnt++;
    tot_cnt++; if (bus.o_mask !== 2'b11) $display("FAIL rst_mask act=%b exp=11", bus.o_mask); else pass_cnt++;
    tot_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", bus.o_busy); else pass_cnt++;
    rst = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic_a();
    bus.i_mask_we = 1'b1; bus.i_mask = 2'b00;
    cyc(1);
    bus.i_mask_we = 1'b0;
    tot_cnt++; if (bus.o_mask !== 2'b00) $display("FAIL basic_mask act=%b exp=00", bus.o_mask); else pass_cnt++;
    i_inta = 1'b1;
    cyc(2);
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL basic_pend_early act=%b exp=00", bus.o_pending); else pass_cnt++;
    cyc(1);
    tot_cnt++; if (bus.o_pending !== 2'b01) $display("FAIL basic_pend act=%b exp=01", bus.o_pending); else pass_cnt++;
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL basic_req_early act=%b exp=0", bus.o_int_req); else pass_cnt++;
    i_inta = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL basic_req act=%b exp=1", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'hFF00) $display("FAIL basic_vec act=%h exp=ff00", bus.o_int_vector); else pass_cnt++;
    tot_cnt++; if (bus.o_int_id !== 1'b0) $display("FAIL basic_id act=%b exp=0", bus.o_int_id); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    tot_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL basic_busy act=%b exp=1", bus.o_busy); else pass_cnt++;
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL basic_req_ack act=%b exp=0", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL basic_pend_ack act=%b exp=00", bus.o_pending); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    tot_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL basic_busy_eoi act=%b exp=0", bus.o_busy); else pass_cnt++;
    // Stray ack/eoi while idle must have no effect.
    bus.i_ack = 1'b1; bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0; bus.i_eoi = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL idle_ack_busy act=%b exp=0", bus.o_busy); else pass_cnt++;
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL idle_ack_req act=%b exp=0", bus.o_int_req); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    i_inta = 1'b1; i_intb = 1'b1;
    cyc(3);
    tot_cnt++; if (bus.o_pending !== 2'b11) $display("FAIL sim_pend act=%b exp=11", bus.o_pending); else pass_cnt++;
    i_inta = 1'b0; i_intb = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_id !== 1'b0) $display("FAIL sim_id_a act=%b exp=0", bus.o_int_id); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'hFF00) $display("FAIL sim_vec_a act=%h exp=ff00", bus.o_int_vector); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    tot_cnt++; if (bus.o_pending !== 2'b10) $display("FAIL sim_pend_b act=%b exp=10", bus.o_pending); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL sim_gap_req act=%b exp=0", bus.o_int_req); else pass_cnt++;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL sim_req_b act=%b exp=1", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_id !== 1'b1) $display("FAIL sim_id_b act=%b exp=1", bus.o_int_id); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'hFF04) $display("FAIL sim_vec_b act=%h exp=ff04", bus.o_int_vector); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL sim_pend_end act=%b exp=00", bus.o_pending); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
  endtask

  task automatic test_mask();
    bus.i_mask_we = 1'b1; bus.i_mask = 2'b01;
    cyc(1);
    bus.i_mask_we = 1'b0;
    i_inta = 1'b1;
    cyc(3);
    tot_cnt++; if (bus.o_pending !== 2'b01) $display("FAIL mask_pend act=%b exp=01", bus.o_pending); else pass_cnt++;
    i_inta = 1'b0;
    cyc(1);
    // Second edge on an already pending source is absorbed.
    i_inta = 1'b1;
    cyc(1);
    i_inta = 1'b0;
    cyc(3);
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL mask_noreq act=%b exp=0", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_pending !== 2'b01) $display("FAIL mask_pend_hold act=%b exp=01", bus.o_pending); else pass_cnt++;
    bus.i_mask_we = 1'b1; bus.i_mask = 2'b00;
    cyc(1);
    bus.i_mask_we = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL mask_unmask_req act=%b exp=1", bus.o_int_req); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    cyc(4);
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL mask_absorb_pend act=%b exp=00", bus.o_pending); else pass_cnt++;
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL mask_absorb_req act=%b exp=0", bus.o_int_req); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    i_inta = 1'b1;
    cyc(3);
    i_inta = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL setw_req act=%b exp=1", bus.o_int_req); else pass_cnt++;
    i_inta = 1'b1;
    cyc(1);
    i_inta = 1'b0;
    cyc(1);
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    tot_cnt++; if (bus.o_pending !== 2'b01) $display("FAIL setw_pend act=%b exp=01", bus.o_pending); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL setw_rereq act=%b exp=1", bus.o_int_req); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL setw_pend_end act=%b exp=00", bus.o_pending); else pass_cnt++;
  endtask

  task automatic test_preempt();
    i_intb = 1'b1;
    cyc(3);
    i_intb = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_vector !== 16'hFF04) $display("FAIL pre_vec_b act=%h exp=ff04", bus.o_int_vector); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    i_inta = 1'b1;
    cyc(3);
    i_inta = 1'b0;
    tot_cnt++; if (bus.o_pending !== 2'b01) $display("FAIL pre_pend_a act=%b exp=01", bus.o_pending); else pass_cnt++;
    cyc(1);
`ifdef INTC_NESTING_EN
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL nest_req act=%b exp=1", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'hFF00) $display("FAIL nest_vec act=%h exp=ff00", bus.o_int_vector); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    tot_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL nest_busy act=%b exp=1", bus.o_busy); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    tot_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL nest_busy_ret act=%b exp=1", bus.o_busy); else pass_cnt++;
    tot_cnt++; if (bus.o_int_id !== 1'b1) $display("FAIL nest_id_ret act=%b exp=1", bus.o_int_id); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'hFF04) $display("FAIL nest_vec_ret act=%h exp=ff04", bus.o_int_vector); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    tot_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL nest_busy_end act=%b exp=0", bus.o_busy); else pass_cnt++;
`else
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL pre_noreq act=%b exp=0", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_id !== 1'b1) $display("FAIL pre_id_b act=%b exp=1", bus.o_int_id); else pass_cnt++;
    tot_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL pre_busy act=%b exp=1", bus.o_busy); else pass_cnt++;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL pre_req_a act=%b exp=1", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'hFF00) $display("FAIL pre_vec_a act=%h exp=ff00", bus.o_int_vector); else pass_cnt++;
    bus.i_ack = 1'b1;
    cyc(1);
    bus.i_ack = 1'b0;
    bus.i_eoi = 1'b1;
    cyc(1);
    bus.i_eoi = 1'b0;
    tot_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL pre_busy_end act=%b exp=0", bus.o_busy); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    i_inta = 1'b1;
    cyc(3);
    i_inta = 1'b0;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b1) $display("FAIL rmid_req_pre act=%b exp=1", bus.o_int_req); else pass_cnt++;
    rst = 1'b1;
    cyc(1);
    tot_cnt++; if (bus.o_int_req !== 1'b0) $display("FAIL rmid_req act=%b exp=0", bus.o_int_req); else pass_cnt++;
    tot_cnt++; if (bus.o_int_vector !== 16'h0000) $display("FAIL rmid_vec act=%h exp=0000", bus.o_int_vector); else pass_cnt++;
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL rmid_pend act=%b exp=00", bus.o_pending); else pass_cnt++;
    tot_cnt++; if (bus.o_mask !== 2'b11) $display("FAIL rmid_mask act=%b exp=11", bus.o_mask); else pass_cnt++;
    tot_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rmid_busy act=%b exp=0", bus.o_busy); else pass_cnt++;
  endtask

  task automatic test_reset_edge();
    rst = 1'b1;
    i_inta = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL redge_pend act=%b exp=00", bus.o_pending); else pass_cnt++;
    i_inta = 1'b0;
    cyc(6);
    tot_cnt++; if (bus.o_pending !== 2'b00) $display("FAIL redge_pend_fall act=%b exp=00", bus.o_pending); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    rst = 1'b1;
    i_inta = 1'b0;
    i_intb = 1'b0;
    bus.i_mask_we = 1'b0;
    bus.i_mask = 2'b00;
    bus.i_ack = 1'b0;
    bus.i_eoi = 1'b0;
    test_reset();
    test_basic_a();
    test_simultaneous();
    test_mask();
    test_set_wins();
    test_preempt();
    test_reset_mid();
    test_reset_edge();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
